leaf_stub: RTL



---
 rtl/leaf_pkg.sv | 48 ++++
 rtl/leaf_stub_fifo.sv | 63 ++++++
 rtl/leaf_stub.sv | 129 ++++++++++++
 3 files changed

// File: rtl/leaf_pkg.sv
// Packet layout, mode constants and header helpers shared by the leaf stub.
package leaf_pkg;

  // Field widths of a BFT packet, MSB first: valid, leaf, port, addr, payload.
  localparam int PKT_PAYLOAD_W = 32;
  localparam int PKT_ADDR_W    = 7;
  localparam int PKT_PORT_W    = 4;
  localparam int PKT_LEAF_W    = 5;
  localparam int PKT_W         = 1 + PKT_LEAF_W + PKT_PORT_W + PKT_ADDR_W + PKT_PAYLOAD_W;

  // Field offsets derived from the widths above.
  localparam int ADDR_LSB  = PKT_PAYLOAD_W;
  localparam int PORT_LSB  = ADDR_LSB + PKT_ADDR_W;
  localparam int LEAF_LSB  = PORT_LSB + PKT_PORT_W;
  localparam int VALID_BIT = LEAF_LSB + PKT_LEAF_W;

  // Operating modes of the stub.
  localparam int MODE_SINK = 0;
  localparam int MODE_ECHO = 1;

  typedef logic [PKT_W-1:0]      pkt_t;
  typedef logic [PKT_LEAF_W-1:0] leaf_t;
  typedef logic [PKT_PORT_W-1:0] port_t;

  function automatic logic pkt_valid(input pkt_t p);
    return p[VALID_BIT];
  endfunction

  function automatic port_t pkt_port(input pkt_t p);
    return p[PORT_LSB +: PKT_PORT_W];
  endfunction

  function automatic leaf_t pkt_leaf(input pkt_t p);
    return p[LEAF_LSB +: PKT_LEAF_W];
  endfunction

  // Rewrite the header to a new destination; the word is marked valid,
  // addr and payload pass through untouched.
  function automatic pkt_t pkt_set_dest(input pkt_t p, input leaf_t leaf, input port_t port);
    pkt_t r;
    r = p;
    r[VALID_BIT] = 1'b1;
    r[LEAF_LSB +: PKT_LEAF_W] = leaf;
    r[PORT_LSB +: PKT_PORT_W] = port;
    return r;
  endfunction

endpackage

// File: rtl/leaf_stub_fifo.sv
// Small synchronous FIFO holding echoed packets. The head word is always
// visible on data_o; pop_i consumes it on the rising edge. Callers only
// pop when non-empty and only push when non-full or popping.
module leaf_stub_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Next pointers wrap naturally; occupancy moves only on push xor pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/leaf_stub.sv
// Stand-in leaf for an unused BFT leaf slot. Drains every packet so the
// network never stalls, counts accepted/dropped packets, and in echo mode
// returns accepted packets to a fixed leaf/port.
//
// Output handshake: a non-zero word on dout_leaf_interface2bft is offered
// to the BFT; when resend is high in that cycle the BFT did not take it and
// the same word is re-presented next cycle. A word is consumed on any edge
// where resend is low.
module leaf_stub
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS   = PKT_W,
  parameter int PAYLOAD_BITS  = PKT_PAYLOAD_W,
  parameter int NUM_LEAF_BITS = PKT_LEAF_W,
  parameter int NUM_PORT_BITS = PKT_PORT_W,
  parameter int NUM_ADDR_BITS = PKT_ADDR_W,
  parameter int PORT_BASE     = 2,
  parameter int NUM_IN_PORTS  = 1,
  parameter int MODE          = MODE_SINK,
  parameter int FIFO_DEPTH    = 4,
  parameter int RETURN_LEAF   = 0,
  parameter int RETURN_PORT   = 2,
  parameter int CNT_BITS      = 16
) (
  input  logic                   clk_bft,
  input  logic                   reset_bft,
  input  logic [PACKET_BITS-1:0] din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0] dout_leaf_interface2bft,
  input  logic                   resend,
  input  logic                   ap_start,
  output logic [CNT_BITS-1:0]    rx_count,
  output logic [CNT_BITS-1:0]    drop_count
);

  logic                          in_valid;
  logic                          in_range;
  port_t                         in_port;
  pkt_t                          echo_word;
  logic                          rx_inc;
  logic                          drop_inc;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [CNT_BITS-1:0]           rx_cnt_q, rx_cnt_d;
  logic [CNT_BITS-1:0]           drop_cnt_q, drop_cnt_d;
  logic                          unused_ok;

  // Input is ignored entirely while reset is asserted.
  assign in_valid  = ~reset_bft & pkt_valid(din_leaf_bft2interface);
  assign in_port   = pkt_port(din_leaf_bft2interface);
  assign in_range  = in_valid && (int'(in_port) >= PORT_BASE)
                              && (int'(in_port) < PORT_BASE + NUM_IN_PORTS);
  assign echo_word = pkt_set_dest(din_leaf_bft2interface,
                                  leaf_t'(RETURN_LEAF), port_t'(RETURN_PORT));

  // Inputs and side values that only matter in echo mode.
  assign unused_ok = ^{ap_start, resend, echo_word, fifo_count};

  if (MODE == MODE_ECHO) begin : g_echo
    logic [PACKET_BITS-1:0] out_pkt_q, out_pkt_d;
    logic [PACKET_BITS-1:0] fifo_head;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;

    // Pop whenever the output register is free to move and data waits.
    assign pop  = ~reset_bft & ~resend & ~fifo_empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push = in_range & ap_start & (~fifo_full | pop);

    assign rx_inc   = push;
    assign drop_inc = in_valid & ~push;

    leaf_stub_fifo #(
      .WIDTH (PACKET_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_bft),
      .rst_i   (reset_bft),
      .push_i  (push),
      .data_i  (echo_word),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
    );

    // Output word: hold on resend, else take the FIFO head, else idle zero.
    always_comb begin
      out_pkt_d = '0;
      if (resend)           out_pkt_d = out_pkt_q;
      else if (!fifo_empty) out_pkt_d = fifo_head;
    end

    // Output register; reset discards any held packet.
    always_ff @(posedge clk_bft) begin
      if (reset_bft) out_pkt_q <= '0;
      else           out_pkt_q <= out_pkt_d;
    end

    assign dout_leaf_interface2bft = out_pkt_q;
  end else begin : g_sink
    assign rx_inc                  = in_range;
    assign drop_inc                = in_valid & ~in_range;
    assign fifo_count              = '0;
    assign dout_leaf_interface2bft = '0;
  end

  // Saturating counters: stick at all-ones instead of wrapping.
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (rx_inc && (rx_cnt_q != '1))     rx_cnt_d   = rx_cnt_q + 1'b1;
    if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_count   = rx_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule
